// File: rtl/mul_pipe.sv
// mul_pipe: pipelined radix-4 Booth MULT/MADD/MSUB unit with valid/ready, tags, stall and flush.
// Define MUL_OVF_FLAG_EN to add the out_ovf result flag; the default build omits it.
module mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic [2*WIDTH-1:0]   in_acc,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic [TAG_W-1:0]     out_tag,
`ifdef MUL_OVF_FLAG_EN
  output logic                 out_ovf,
`endif
  output logic                 busy
);

  localparam int ZW   = 2 * WIDTH;
  localparam int NPP  = WIDTH / 2 + 1;
  localparam int NROW = NPP + 1;

  typedef logic [NROW-1:0][ZW-1:0] rows_t;

  function automatic int rows_after(input int n, input int lev);
    int c;
    c = n;
    for (int l = 0; l < lev; l++)
      if (c > 2) c = (c / 3) * 2 + c % 3;
    return c;
  endfunction

  function automatic int total_levels(input int n);
    int c, l;
    c = n;
    l = 0;
    for (int i = 0; i < 64; i++)
      if (c > 2) begin
        c = (c / 3) * 2 + c % 3;
        l++;
      end
    return l;
  endfunction

  localparam int TL   = total_levels(NROW);
  localparam int NMID = LATENCY - 2;

  // Last CSA level finished by middle stage j; levels are spread evenly over the middle stages.
  function automatic int lev_end(input int j);
    if (NMID == 0) return TL;
    return (j * TL) / NMID;
  endfunction

  function automatic logic [ZW-1:0] booth_pp(input logic [2:0] d, input logic [ZW-1:0] xs,
                                             input int sh);
    logic [ZW-1:0] m;
    case (d)
      3'b001, 3'b010: m = xs;
      3'b011:         m = xs << 1;
      3'b100:         m = -(xs << 1);
      3'b101, 3'b110: m = -xs;
      default:        m = '0;
    endcase
    return m << sh;
  endfunction

  // Applies nlev 3:2 levels to the first cnt rows; results are packed to the low rows, rest zero.
  function automatic rows_t csa_reduce(input rows_t r, input int cnt, input int nlev);
    rows_t cur, nxt;
    int c, o;
    cur = r;
    c = cnt;
    for (int l = 0; l < TL; l++) begin
      if (l < nlev && c > 2) begin
        nxt = '0;
        o = 0;
        for (int i = 0; i + 2 < NROW; i += 3)
          if (i + 2 < c) begin
            nxt[o]     = cur[i] ^ cur[i+1] ^ cur[i+2];
            nxt[o + 1] = ((cur[i] & cur[i+1]) | (cur[i] & cur[i+2]) | (cur[i+1] & cur[i+2])) << 1;
            o += 2;
          end
        for (int i = 0; i < NROW; i++)
          if (i >= (c / 3) * 3 && i < c) begin
            nxt[o] = cur[i];
            o++;
          end
        cur = nxt;
        c = (c / 3) * 2 + c % 3;
      end
    end
    return cur;
  endfunction

`ifdef MUL_OVF_FLAG_EN
  // mode = {madd, msub, signed, product_negative}
  function automatic logic ovf_flag(input logic [ZW-1:0] z, input logic [ZW-1:0] acc,
                                    input logic [3:0] mode);
    logic r;
    r = 1'b0;
    if (mode[3] || mode[2]) begin
      if (mode[1]) begin
        if (mode[3]) r = (mode[0] == acc[ZW-1]) && (z[ZW-1] != mode[0]);
        else         r = (acc[ZW-1] != mode[0]) && (z[ZW-1] != acc[ZW-1]);
      end else begin
        r = mode[3] ? (z < acc) : (z > acc);
      end
    end
    return r;
  endfunction
`endif

  logic [LATENCY:1]   vld_p;
  logic [LATENCY:1]   adv;
  rows_t              rows_p [1:LATENCY-1];
  logic [TAG_W-1:0]   tag_p  [1:LATENCY-1];
  rows_t              rows_in;
  logic [ZW-1:0]      pp;
  logic [WIDTH:0]     xe;
  logic [WIDTH+1:0]   ye;
  logic [WIDTH+2:0]   yb;
  logic [ZW-1:0]      xs;
  logic [ZW-1:0]      sum;
  rows_t              fin;
`ifdef MUL_OVF_FLAG_EN
  logic [ZW-1:0]      acc_p  [1:LATENCY-1];
  logic [3:0]         mode_p [1:LATENCY-1];
  logic [3:0]         mode_in;
`endif

  // Advance chain: a stage may load when it is empty or its successor is taking its content.
  always_comb begin
    logic go;
    go = !stall && (!vld_p[LATENCY] || out_ready);
    adv = '0;
    adv[LATENCY] = go;
    for (int k = LATENCY - 1; k >= 1; k--) begin
      go = !stall && (!vld_p[k] || go);
      adv[k] = go;
    end
  end

  assign in_ready  = !flush && adv[1];
  assign out_valid = vld_p[LATENCY];
  assign busy      = |vld_p;

  always_comb begin
    xe = {in_signed & in_x[WIDTH-1], in_x};
    ye = {{2{in_signed & in_y[WIDTH-1]}}, in_y};
    yb = {ye, 1'b0};
    xs = {{(ZW-WIDTH-1){xe[WIDTH]}}, xe};
    pp = '0;
    rows_in = '0;
    for (int i = 0; i < NPP; i++) begin
      pp = booth_pp(yb[2*i +: 3], xs, 2 * i);
      rows_in[i] = (in_op == 2'b10) ? -pp : pp;
    end
    rows_in[NROW-1] = (in_op == 2'b01 || in_op == 2'b10) ? in_acc : '0;
  end

`ifdef MUL_OVF_FLAG_EN
  assign mode_in = {in_op == 2'b01, in_op == 2'b10, in_signed,
                    in_signed & (in_x[WIDTH-1] ^ in_y[WIDTH-1]) & (|in_x) & (|in_y)};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      if (adv[1]) vld_p[1] <= in_valid;
      for (int k = 2; k <= LATENCY; k++)
        if (adv[k]) vld_p[k] <= vld_p[k-1];
      if (!adv[LATENCY] && out_ready) vld_p[LATENCY] <= 1'b0;
    end
  end

  // Stage 1 holds partial products + accumulator term; middle stages hold CSA-reduced rows.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      rows_p[1] <= rows_in;
      tag_p[1]  <= in_tag;
`ifdef MUL_OVF_FLAG_EN
      acc_p[1]  <= in_acc;
      mode_p[1] <= mode_in;
`endif
    end
    for (int k = 2; k < LATENCY; k++)
      if (adv[k] && vld_p[k-1]) begin
        rows_p[k] <= csa_reduce(rows_p[k-1], rows_after(NROW, lev_end(k - 2)),
                                lev_end(k - 1) - lev_end(k - 2));
        tag_p[k]  <= tag_p[k-1];
`ifdef MUL_OVF_FLAG_EN
        acc_p[k]  <= acc_p[k-1];
        mode_p[k] <= mode_p[k-1];
`endif
      end
  end

  // Final stage: finish any remaining CSA levels, then the carry-propagate add.
  always_comb begin
    fin = rows_p[LATENCY-1];
    if (NMID == 0) fin = csa_reduce(fin, NROW, TL);
    sum = '0;
    for (int i = 0; i < NROW; i++) sum = sum + fin[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_z   <= '0;
      out_tag <= '0;
`ifdef MUL_OVF_FLAG_EN
      out_ovf <= 1'b0;
`endif
    end else if (adv[LATENCY] && vld_p[LATENCY-1]) begin
      out_z   <= sum;
      out_tag <= tag_p[LATENCY-1];
`ifdef MUL_OVF_FLAG_EN
      out_ovf <= ovf_flag(sum, acc_p[LATENCY-1], mode_p[LATENCY-1]);
`endif
    end
  end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, fully pipelined radix-4 Booth multiply/accumulate unit for the EX stage. It generalises the fixed 32-bit HI/LO multiplier to any even WIDTH and a configurable LATENCY.
- Adds valid/ready handshakes, per-op tags and back-pressure.
- Performs signed or unsigned MULT, MADD and MSUB against a caller-supplied 2*WIDTH accumulator. Accepts one op per cycle.

Parameters:
- WIDTH, 32, operand width; must be even and >= 8.
- LATENCY, 3, pipeline stages from accept to out_valid; legal values 2..4.
- TAG_W, 4, width of the opaque tag carried with each op.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill all in-flight ops.
- stall  in  1  freeze the pipeline.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted when in_valid && in_ready.
- in_op  in  2  00 MULT, 01 MADD, 10 MSUB; 11 is treated as MULT.
- in_signed  in  1  1 = signed, 0 = unsigned.
- in_x  in  WIDTH  multiplicand.
- in_y  in  WIDTH  multiplier.
- in_acc  in  2*WIDTH  accumulator {HI,LO}; ignored for MULT.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_z  out  2*WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any stage holds a valid op.

Behaviour:
- Reset (rst=0): takes effect asynchronously.
  - Clears all stage valid bits.
  - out_valid=0, out_z=0, out_tag=0, busy=0.
  - After reset release, in_ready=1 whenever stall=0.
- Arithmetic:
  - x is extended to WIDTH+1 bits and y to WIDTH+2 bits, sign-extended if in_signed else zero-extended.
  - Radix-4 Booth encoding produces WIDTH/2+1 partial products, each 2*WIDTH wide.
  - MSUB negates every partial product.
  - The accumulator term is 0 for MULT and in_acc otherwise.
  - The sum is reduced with 3:2 CSA levels and one final carry-propagate add.
  - All arithmetic is modulo 2^(2*WIDTH); there is no saturation.
- Pipeline:
  - Stage 1 registers the partial products and the accumulator term.
  - The CSA tree is split across the middle stages; the final add feeds the output register (stage LATENCY).
  - Each stage has its own valid bit; tag and op travel with the data.
- Advance rule:
  - Stage k loads from stage k-1 when stage k is empty or is itself advancing.
  - The output stage advances when !out_valid || out_ready.
  - Bubbles collapse, so throughput is 1 op/cycle while out_ready=1.
- in_ready = !stall && !flush && (stage1 empty || stage1 advancing). It is combinational.
- Output hold: while out_valid && !out_ready, out_z and out_tag stay stable.
- stall=1: no stage loads and all valid bits hold; out_valid/out_z still present, and a transfer on out_ready still retires the output stage.
- flush=1: every valid bit, including the output stage, clears on the next edge.
  - An input offered in the same cycle is not accepted.
  - Flush takes priority over stall, in_valid and out_ready.
  - Data registers need not clear.
- Empty pipeline: an op accepted at edge t drives out_valid=1 after edge t+LATENCY-1, i.e. out_valid rises LATENCY cycles after the accept cycle.
- busy = OR of all stage valid bits.

Optional Feature:
- MUL_OVF_FLAG_EN: adds output out_ovf (1 bit), carried with the result.
- When defined, for MADD/MSUB:
  - signed: out_ovf=1 when the exact product ± acc does not fit in signed 2*WIDTH.
  - unsigned: out_ovf=1 on carry out / borrow.
  - out_ovf=0 for MULT; out_ovf resets to 0.
- When undefined, the port is absent and no detection logic is built.

Test Plan (WIDTH=32, LATENCY=3):
- Signed MULT x=0xFFFFFFFF, y=0x00000002 -> out_z=0xFFFFFFFF_FFFFFFFE, out_valid 3 cycles after accept.
- Unsigned MULT x=y=0xFFFFFFFF -> 0xFFFFFFFE_00000001. Signed MULT of the same operands -> 0x00000000_00000001.
- Signed MSUB x=3, y=4, acc=0x10 -> 0x4. Unsigned MADD x=1, y=1, acc=0xFFFFFFFF_FFFFFFFF -> 0x0, with out_ovf=1 if enabled.
- 5 back-to-back ops, tags 0..4, out_ready=0 for 4 cycles:
  - in_ready drops once all 3 stages are full.
  - No op is lost and results emerge in tag order 0..4.
  - out_z stays stable while held.
- 2 ops in flight, flush=1 together with in_valid=1:
  - Next cycle out_valid=0, busy=0, and the offered op is not accepted.
  - An op issued afterwards returns the correct result.
- rst driven low mid-operation with no clock edge -> out_valid, out_z and busy go to 0 immediately. After release, a new MULT 7*6 -> 0x2A.
